// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package booth_pkg;

    // Recoded radix-4 digit selecting which multiple of M is accumulated.
    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_e;

    // Operation sequencing: waiting for operands, iterating, holding a result.
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    // Number of radix-4 digits needed to cover a (width+2)-bit extended multiplier.
    function automatic int booth_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window (b[2i+1], b[2i], b[2i-1])
// onto the digit that scales the multiplicand this iteration.
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0]   window,
    output booth_digit_e digit
);

    // Standard radix-4 recoding table.
    always_comb begin
        digit = ZERO;
        case (window)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides.
// One radix-4 digit is retired per clock; the full 2*WIDTH-bit product is exact
// in both signed and unsigned mode. WIDTH must be even and at least 4.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int ITER  = booth_iter(WIDTH);
    localparam int CNT_W = $clog2(ITER);
    localparam int PW    = 2 * WIDTH;
    // Extended multiplier (WIDTH+2 bits) plus the implicit b[-1] at bit 0.
    localparam int BW    = WIDTH + 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_e           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [PW-1:0]    acc_reg;
    logic [PW-1:0]    m_reg;
    logic [BW-1:0]    b_reg;
    logic             out_valid_reg;

    logic [PW-1:0]    mcand_ext;
    logic [BW-1:0]    mplier_ext;
    booth_digit_e     digit;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_next;
    logic             in_xfer;

    // Operand extension applied at capture: the sign bit only propagates in signed mode.
    assign mcand_ext  = {{WIDTH{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
    assign mplier_ext = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier, 1'b0};

    // Ready in IDLE, or in DONE when the consumer is taking the current product
    // this same cycle so a new operation can start back-to-back.
    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign in_xfer  = in_valid && in_ready;

    assign out_valid = out_valid_reg;
    assign product   = acc_reg;

    booth_r4_enc u_enc (
        .window (b_reg[2:0]),
        .digit  (digit)
    );

    // Select the digit multiple of M; negative multiples are two's-complement negates,
    // which stay exact because all accumulation is modulo 2^(2*WIDTH).
    always_comb begin
        addend = '0;
        case (digit)
            POS1:    addend = m_reg;
            POS2:    addend = m_reg << 1;
            NEG1:    addend = ~m_reg + PW'(1);
            NEG2:    addend = ~(m_reg << 1) + PW'(1);
            default: addend = '0;
        endcase
    end

    assign acc_next = acc_reg + addend;

    // Control FSM and datapath registers: capture, iterate ITER digits, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            m_reg         <= '0;
            b_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_xfer) begin
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    acc_reg <= acc_next;
                    m_reg   <= m_reg << 2;
                    b_reg   <= b_reg >> 2;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg       <= '0;
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= in_xfer ? BUSY : IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                end
            endcase

            // Operand capture is shared by the IDLE start and the back-to-back start in DONE.
            if (in_xfer) begin
                acc_reg <= '0;
                cnt_reg <= '0;
                m_reg   <= mcand_ext;
                b_reg   <= mplier_ext;
            end
        end
    end

endmodule
